// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a 32-bit MIPS-style datapath.
// Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Control outputs are held in registers loaded with the decode of the state
// being entered, so they always reflect the current state. The only exception
// is pc_en, which also depends on the live ALU zero flag.
module multicycle_ctrl #(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero_flag,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           pc_en,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [2:0]     alu_func,
    output logic [1:0]     pc_src,
    output logic           illegal,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_func;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_NOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_LUI  = 3'd6;
    localparam logic [2:0] ALU_ZERO = 3'd7;

    // R-type funct to ALU code; ALU_ZERO marks an unsupported funct.
    function automatic logic [2:0] r_func_f(input logic [FNW-1:0] fn);
        logic [2:0] f;
        case (fn)
            6'b100000: f = ALU_ADD;
            6'b100010: f = ALU_SUB;
            6'b100100: f = ALU_AND;
            6'b100101: f = ALU_OR;
            6'b100111: f = ALU_NOR;
            6'b101010: f = ALU_SLT;
            default:   f = ALU_ZERO;
        endcase
        return f;
    endfunction

    // I-type ALU opcode to ALU code.
    function automatic logic [2:0] i_func_f(input logic [OPW-1:0] op);
        logic [2:0] f;
        case (op)
            OP_ADDI: f = ALU_ADD;
            OP_ANDI: f = ALU_AND;
            OP_ORI:  f = ALU_OR;
            OP_SLTI: f = ALU_SLT;
            OP_LUI:  f = ALU_LUI;
            default: f = ALU_ZERO;
        endcase
        return f;
    endfunction

    // Transition function; zero_flag deliberately plays no part here.
    function automatic state_t next_state_f(input state_t st,
                                            input logic [OPW-1:0] op,
                                            input logic [FNW-1:0] fn);
        state_t ns;
        case (st)
            S_FETCH:  ns = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                                    ns = S_EXEC_R;
                    OP_LW, OP_SW:                                ns = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI:   ns = S_EXEC_I;
                    OP_BEQ:                                      ns = S_BRANCH;
                    OP_J:                                        ns = S_JUMP;
                    default:                                     ns = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: ns = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   ns = S_WB_MEM;
            S_EXEC_R:   ns = (r_func_f(fn) == ALU_ZERO) ? S_ILLEGAL : S_WB_ALU;
            S_EXEC_I:   ns = S_WB_ALU;
            default:    ns = S_FETCH;
        endcase
        return ns;
    endfunction

    // Moore output decode for a given state; unlisted fields stay 0.
    function automatic ctrl_t decode_f(input state_t st,
                                       input logic [OPW-1:0] op,
                                       input logic [FNW-1:0] fn,
                                       input logic rdst);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'd1;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_func  = r_func_f(fn);
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.alu_func  = i_func_f(op);
            end
            S_WB_ALU: begin
                c.reg_write = 1'b1;
                c.reg_dst   = rdst;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_func      = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'd1;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'd2;
            end
            S_ILLEGAL: c.illegal = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    logic   reg_dst_sel_r;
    logic   reg_dst_next_s;

    // Next-state selection from the current state and instruction fields.
    always_comb begin
        next_state_s = next_state_f(state_r, opcode, funct);
    end

    // Destination-register select: rd for R-type, rt for I-type, else hold.
    always_comb begin
        reg_dst_next_s = reg_dst_sel_r;
        case (state_r)
            S_EXEC_R: reg_dst_next_s = 1'b1;
            S_EXEC_I: reg_dst_next_s = 1'b0;
            default:  reg_dst_next_s = reg_dst_sel_r;
        endcase
    end

    // State register plus control registers preloaded with the entered state's decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_FETCH;
            reg_dst_sel_r <= 1'b0;
            ctrl_r        <= decode_f(S_FETCH, opcode, funct, 1'b0);
        end else begin
            state_r       <= next_state_s;
            reg_dst_sel_r <= reg_dst_next_s;
            ctrl_r        <= decode_f(next_state_s, opcode, funct, reg_dst_next_s);
        end
    end

    assign pc_write      = ctrl_r.pc_write;
    assign pc_write_cond = ctrl_r.pc_write_cond;
    assign iord          = ctrl_r.iord;
    assign mem_read      = ctrl_r.mem_read;
    assign mem_write     = ctrl_r.mem_write;
    assign ir_write      = ctrl_r.ir_write;
    assign reg_dst       = ctrl_r.reg_dst;
    assign mem_to_reg    = ctrl_r.mem_to_reg;
    assign reg_write     = ctrl_r.reg_write;
    assign alu_src_a     = ctrl_r.alu_src_a;
    assign alu_src_b     = ctrl_r.alu_src_b;
    assign alu_func      = ctrl_r.alu_func;
    assign pc_src        = ctrl_r.pc_src;
    assign illegal       = ctrl_r.illegal;
    assign state         = state_r;

    // Branch resolution is the only path from zero_flag into the controller.
    assign pc_en = ctrl_r.pc_write | (ctrl_r.pc_write_cond & zero_flag);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks the control outputs in each state.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_flag;
    logic       pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_func;
    logic [3:0] state;

    int tests_run;
    int tests_failed;

    multicycle_ctrl #(.OPW(6), .FNW(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_func(alu_func), .pc_src(pc_src), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        opcode    = 6'b100011;
        funct     = 6'b000000;
        zero_flag = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("por_state", 32'(state), 32'd0);

        // lw interrupted by reset in MEM_RD
        tick(); chk("lw_pre_dec", 32'(state), 32'd1);
        tick(); chk("lw_pre_addr", 32'(state), 32'd2);
        tick(); chk("lw_pre_rd", 32'(state), 32'd3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd1);
        chk("rst_ir_write", 32'(ir_write), 32'd1);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);

        // R-type add
        opcode = 6'b000000; funct = 6'b100000;
        tick(); chk("add_dec", 32'(state), 32'd1);
        chk("add_dec_srcb", 32'(alu_src_b), 32'd3);
        tick(); chk("add_exec", 32'(state), 32'd6);
        chk("add_func", 32'(alu_func), 32'd0);
        chk("add_srca", 32'(alu_src_a), 32'd1);
        tick(); chk("add_wb", 32'(state), 32'd8);
        chk("add_reg_write", 32'(reg_write), 32'd1);
        chk("add_reg_dst", 32'(reg_dst), 32'd1);
        chk("add_mem_to_reg", 32'(mem_to_reg), 32'd0);
        tick(); chk("add_fetch", 32'(state), 32'd0);

        // R-type nor
        funct = 6'b100111;
        tick(); chk("nor_dec", 32'(state), 32'd1);
        tick(); chk("nor_exec", 32'(state), 32'd6);
        chk("nor_func", 32'(alu_func), 32'd4);
        tick(); chk("nor_wb", 32'(state), 32'd8);
        chk("nor_reg_write", 32'(reg_write), 32'd1);
        tick(); chk("nor_fetch", 32'(state), 32'd0);

        // lw
        opcode = 6'b100011;
        tick(); chk("lw_dec", 32'(state), 32'd1);
        tick(); chk("lw_addr", 32'(state), 32'd2);
        chk("lw_addr_srcb", 32'(alu_src_b), 32'd2);
        tick(); chk("lw_rd", 32'(state), 32'd3);
        chk("lw_iord", 32'(iord), 32'd1);
        chk("lw_mem_read", 32'(mem_read), 32'd1);
        tick(); chk("lw_wb", 32'(state), 32'd4);
        chk("lw_reg_write", 32'(reg_write), 32'd1);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("lw_reg_dst", 32'(reg_dst), 32'd0);
        tick(); chk("lw_fetch", 32'(state), 32'd0);

        // sw
        opcode = 6'b101011;
        tick(); chk("sw_dec", 32'(state), 32'd1);
        chk("sw_dec_mem_write", 32'(mem_write), 32'd0);
        tick(); chk("sw_addr", 32'(state), 32'd2);
        chk("sw_addr_mem_write", 32'(mem_write), 32'd0);
        tick(); chk("sw_wr", 32'(state), 32'd5);
        chk("sw_mem_write", 32'(mem_write), 32'd1);
        chk("sw_iord", 32'(iord), 32'd1);
        chk("sw_reg_write", 32'(reg_write), 32'd0);
        tick(); chk("sw_fetch", 32'(state), 32'd0);
        chk("sw_fetch_mem_write", 32'(mem_write), 32'd0);

        // beq, taken then not taken within the BRANCH cycle
        opcode = 6'b000100; zero_flag = 1'b1;
        tick(); chk("beq_dec", 32'(state), 32'd1);
        chk("beq_dec_pc_en", 32'(pc_en), 32'd0);
        tick(); chk("beq_br", 32'(state), 32'd9);
        chk("beq_func", 32'(alu_func), 32'd1);
        chk("beq_pc_src", 32'(pc_src), 32'd1);
        chk("beq_pc_en_taken", 32'(pc_en), 32'd1);
        zero_flag = 1'b0;
        #1;
        chk("beq_pc_en_not_taken", 32'(pc_en), 32'd0);
        tick(); chk("beq_fetch", 32'(state), 32'd0);

        // lui
        opcode = 6'b001111;
        tick(); chk("lui_dec", 32'(state), 32'd1);
        tick(); chk("lui_exec", 32'(state), 32'd7);
        chk("lui_func", 32'(alu_func), 32'd6);
        chk("lui_srcb", 32'(alu_src_b), 32'd2);
        tick(); chk("lui_wb", 32'(state), 32'd8);
        chk("lui_reg_write", 32'(reg_write), 32'd1);
        chk("lui_reg_dst", 32'(reg_dst), 32'd0);
        tick(); chk("lui_fetch", 32'(state), 32'd0);

        // j
        opcode = 6'b000010;
        tick(); chk("j_dec", 32'(state), 32'd1);
        tick(); chk("j_jump", 32'(state), 32'd10);
        chk("j_pc_write", 32'(pc_write), 32'd1);
        chk("j_pc_src", 32'(pc_src), 32'd2);
        chk("j_pc_en", 32'(pc_en), 32'd1);
        tick(); chk("j_fetch", 32'(state), 32'd0);

        // illegal opcode
        opcode = 6'b111111;
        tick(); chk("ill_dec", 32'(state), 32'd1);
        chk("ill_dec_flag", 32'(illegal), 32'd0);
        tick(); chk("ill_state", 32'(state), 32'd11);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_reg_write", 32'(reg_write), 32'd0);
        chk("ill_pc_write", 32'(pc_write), 32'd0);
        tick(); chk("ill_fetch", 32'(state), 32'd0);
        chk("ill_flag_clear", 32'(illegal), 32'd0);

        // R-type unsupported funct
        opcode = 6'b000000; funct = 6'b000001;
        tick(); chk("badfn_dec", 32'(state), 32'd1);
        tick(); chk("badfn_exec", 32'(state), 32'd6);
        chk("badfn_func", 32'(alu_func), 32'd7);
        chk("badfn_exec_illegal", 32'(illegal), 32'd0);
        tick(); chk("badfn_ill", 32'(state), 32'd11);
        chk("badfn_flag", 32'(illegal), 32'd1);
        chk("badfn_reg_write", 32'(reg_write), 32'd0);
        tick(); chk("badfn_fetch", 32'(state), 32'd0);
        chk("badfn_flag_clear", 32'(illegal), 32'd0);
        chk("badfn_fetch_mem_read", 32'(mem_read), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
